grayscale_pack_ci: RTL and testbench

GRAYSCALE_PACK_CI -- requirements
Module: grayscale_pack_ci

---
 rtl/grayscale_pkg.sv | 36 +++
 rtl/rgb565_gray_core.sv | 43 ++++
 rtl/grayscale_pack_ci.sv | 179 +++++++++++++++++
 tb/tb_grayscale_pack_ci.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grayscale_pkg.sv
// ---------------------------------------------------------------------------
// grayscale_pkg
//   Shared definitions for the grayscale packing custom instruction:
//   opcode encodings, FSM state encoding, the "packer full" error word,
//   the pack fill level and the luma weights used by the gray core.
// ---------------------------------------------------------------------------
package grayscale_pkg;

    // Opcode carried in valueB[1:0]
    typedef enum logic [1:0] {
        OP_PUSH   = 2'd0,
        OP_READ   = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_STATUS = 2'd3
    } opcode_e;

    // Command FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV0 = 2'd1,
        ST_CONV1 = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Result returned for a push into an already full pack word
    localparam logic [31:0] ERR_FULL_WORD = 32'h8000_0000;

    // Pixel count at which the 4-byte pack word is full
    localparam logic [2:0]  PACK_FULL_CNT = 3'd4;

    // Luma weights; they sum to 256 so white maps exactly to 0xFF
    localparam logic [15:0] GRAY_W_R = 16'd54;
    localparam logic [15:0] GRAY_W_G = 16'd183;
    localparam logic [15:0] GRAY_W_B = 16'd19;

endpackage

// File: rtl/rgb565_gray_core.sv
// ---------------------------------------------------------------------------
// rgb565_gray_core
//   Purely combinational RGB565 -> 8-bit gray converter.
//   Each channel is widened to 8 bits by replicating its MSBs, then
//   gray = (54*R8 + 183*G8 + 19*B8) >> 8, computed in 16 bits.
// Ports
//   pixel : in  [15:0]  RGB565 pixel (R = [15:11], G = [10:5], B = [4:0])
//   gray  : out [7:0]   gray value
// ---------------------------------------------------------------------------
module rgb565_gray_core
    import grayscale_pkg::*;
(
    input  logic [15:0] pixel,
    output logic [7:0]  gray
);

    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    logic        unused_sum_lsb;

    assign r5 = pixel[15:11];
    assign g6 = pixel[10:5];
    assign b5 = pixel[4:0];

    // MSB replication so full-scale 5/6-bit values land on 0xFF
    assign r8 = {r5, r5[4:2]};
    assign g8 = {g6, g6[5:4]};
    assign b8 = {b5, b5[4:2]};

    // Weights sum to 256, so the maximum (65280) fits in 16 bits
    assign sum = (GRAY_W_R * {8'd0, r8})
               + (GRAY_W_G * {8'd0, g8})
               + (GRAY_W_B * {8'd0, b8});

    assign gray           = sum[15:8];
    assign unused_sum_lsb = ^sum[7:0];

endmodule

// File: rtl/grayscale_pack_ci.sv
// ---------------------------------------------------------------------------
// grayscale_pack_ci
//   CPU custom-instruction block that converts pairs of RGB565 pixels to
//   8-bit gray and packs up to four gray bytes into one 32-bit word.
//   Commands (valueB[1:0]): push, read (returns and clears), clear, status.
//   A push time-shares a single gray core over two cycles (CONV0/CONV1).
//
// Configuration
//   GRAYSCALE_PACK_BIG_ENDIAN_EN : when defined, pixel n lands in byte 3-n;
//                                  otherwise pixel n lands in byte n.
//
// Parameters
//   customInstructionId : instruction ID this block answers to
// Ports
//   clock   : in   system clock, rising edge
//   resetn  : in   asynchronous active-low reset
//   start   : in   custom-instruction start strobe
//   iseId   : in   [7:0]  instruction ID of the current start
//   valueA  : in   [31:0] push operand, pixel0 = [15:0], pixel1 = [31:16]
//   valueB  : in   [31:0] opcode in [1:0], rest ignored
//   done    : out  one-cycle completion pulse
//   result  : out  [31:0] result word, zero whenever done is low
// ---------------------------------------------------------------------------
module grayscale_pack_ci
    import grayscale_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    state_e      state_q, state_d;
    logic [31:0] opa_q,   opa_d;
    opcode_e     op_q,    op_d;
    logic [31:0] pack_q,  pack_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [31:0] res_q,   res_d;

    logic        accept;
    logic        full;
    opcode_e     op_in;
    logic [15:0] core_pixel;
    logic [7:0]  core_gray;
    logic        unused_valueb;

    // Write one gray byte into the pack word at arrival index idx
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  val);
        logic [31:0] w;
        logic [1:0]  lane;
`ifdef GRAYSCALE_PACK_BIG_ENDIAN_EN
        lane = 2'd3 - idx;
`else
        lane = idx;
`endif
        w = word;
        w[{lane, 3'b000} +: 8] = val;
        return w;
    endfunction

    assign op_in         = opcode_e'(valueB[1:0]);
    assign unused_valueb = ^valueB[31:2];
    assign full          = (cnt_q == PACK_FULL_CNT);

    // Starts outside IDLE or for another ID are dropped without effect
    assign accept = start && (iseId == customInstructionId) && (state_q == ST_IDLE);

    // Single shared core: low pixel in CONV0, high pixel in CONV1
    assign core_pixel = (state_q == ST_CONV1) ? opa_q[31:16] : opa_q[15:0];

    rgb565_gray_core u_core (
        .pixel (core_pixel),
        .gray  (core_gray)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Only a push with room goes through the conversion steps
                    state_d = (op_in == OP_PUSH && !full) ? ST_CONV0 : ST_DONE;
                end
            end
            ST_CONV0: state_d = ST_CONV1;
            ST_CONV1: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        done   = (state_q == ST_DONE);
        result = done ? res_q : 32'd0;
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        opa_d  = opa_q;
        op_d   = op_q;
        pack_d = pack_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        case (state_q)
            ST_IDLE: begin
                res_d = 32'd0;
                if (accept) begin
                    opa_d = valueA;
                    op_d  = op_in;
                    case (op_in)
                        OP_PUSH:   res_d = full ? ERR_FULL_WORD : 32'd0;
                        OP_READ: begin
                            // Return the word as it stands, then start fresh
                            res_d  = pack_q;
                            pack_d = 32'd0;
                            cnt_d  = 3'd0;
                        end
                        OP_CLEAR: begin
                            pack_d = 32'd0;
                            cnt_d  = 3'd0;
                        end
                        OP_STATUS: res_d = {29'd0, cnt_q};
                        default:   res_d = 32'd0;
                    endcase
                end
            end
            ST_CONV0: begin
                if (op_q == OP_PUSH) begin
                    pack_d = put_byte(pack_q, cnt_q[1:0], core_gray);
                end
            end
            ST_CONV1: begin
                // Count is bumped only once both bytes are in
                if (op_q == OP_PUSH) begin
                    pack_d = put_byte(pack_q, cnt_q[1:0] + 2'd1, core_gray);
                    cnt_d  = cnt_q + 3'd2;
                end
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            opa_q  <= 32'd0;
            op_q   <= OP_PUSH;
            pack_q <= 32'd0;
            cnt_q  <= 3'd0;
            res_q  <= 32'd0;
        end else begin
            opa_q  <= opa_d;
            op_q   <= op_d;
            pack_q <= pack_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
        end
    end

endmodule

// File: tb/tb_grayscale_pack_ci.sv
module tb_grayscale_pack_ci;
    import grayscale_pkg::*;

    localparam logic [7:0] ID = 8'h5A;

`ifdef GRAYSCALE_PACK_BIG_ENDIAN_EN
    localparam logic [31:0] EXP_FOUR = 32'hFF35_B612;
    localparam logic [31:0] EXP_PART = 32'hFF00_0000;
`else
    localparam logic [31:0] EXP_FOUR = 32'h12B6_35FF;
    localparam logic [31:0] EXP_PART = 32'h0000_00FF;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    grayscale_pack_ci #(.customInstructionId(ID)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .iseId  (iseId),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [29:0] hi;
        logic [31:0] want;
        int          lat;
    } vec_t;
    vec_t tbl[18];

    function automatic vec_t mk(input string n, input logic [1:0] op, input logic [31:0] a,
                                input logic [29:0] hi, input logic [31:0] want, input int lat);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.hi = hi; v.want = want; v.lat = lat;
        return v;
    endfunction

    function automatic logic [7:0] gray_ref(input logic [15:0] p);
        int r, g, b, s;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        s = 54 * r + 183 * g + 19 * b;
        return 8'(s / 256);
    endfunction

    function automatic logic [31:0] pack_ref(input logic [7:0] g0, input logic [7:0] g1,
                                             input logic [7:0] g2, input logic [7:0] g3);
`ifdef GRAYSCALE_PACK_BIG_ENDIAN_EN
        return {g0, g1, g2, g3};
`else
        return {g3, g2, g1, g0};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Issue one command, then wait (bounded) for done and compare against the scoreboard
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [29:0] hi, input logic [31:0] want, input int lat);
        exp_t e;
        int   cyc;
        e.res = want;
        e.lat = lat;
        sb.push_back(e);
        @(negedge clock);
        start  = 1'b1;
        iseId  = ID;
        valueA = a;
        valueB = {hi, op};
        @(negedge clock);
        start  = 1'b0;
        valueA = $urandom;
        valueB = $urandom;
        cyc = 1;
        while (done !== 1'b1 && cyc < 12) begin
            @(negedge clock);
            cyc++;
        end
        e = sb.pop_front();
        check({name, " latency"}, 32'(cyc), 32'(e.lat));
        check({name, " result"}, result, e.res);
        @(negedge clock);
        check({name, " pulse width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          nd;
        int          first;
        logic [15:0] p[4];
        logic [31:0] want;

        tbl[0]  = mk("clr0",       OP_CLEAR,  32'h0,         30'h0,        32'h0,         1);
        tbl[1]  = mk("stat0",      OP_STATUS, 32'h0,         30'h0,        32'h0,         1);
        tbl[2]  = mk("push_a",     OP_PUSH,   32'hF800_FFFF, 30'h0,        32'h0,         3);
        tbl[3]  = mk("stat2",      OP_STATUS, 32'h0,         30'h3FFF_FFFF, 32'h2,        1);
        tbl[4]  = mk("push_b",     OP_PUSH,   32'h001F_07E0, 30'h1234_567, 32'h0,         3);
        tbl[5]  = mk("push_full",  OP_PUSH,   32'h0000_0000, 30'h0,        32'h8000_0000, 1);
        tbl[6]  = mk("stat4",      OP_STATUS, 32'h0,         30'h0,        32'h4,         1);
        tbl[7]  = mk("read4",      OP_READ,   32'h0,         30'h0,        EXP_FOUR,      1);
        tbl[8]  = mk("stat_rd",    OP_STATUS, 32'h0,         30'h0,        32'h0,         1);
        tbl[9]  = mk("read_empty", OP_READ,   32'h0,         30'h0,        32'h0,         1);
        tbl[10] = mk("clr1",       OP_CLEAR,  32'h0,         30'h0,        32'h0,         1);
        tbl[11] = mk("push_part",  OP_PUSH,   32'h0000_FFFF, 30'h0,        32'h0,         3);
        tbl[12] = mk("read_part",  OP_READ,   32'h0,         30'h0,        EXP_PART,      1);
        tbl[13] = mk("stat_part",  OP_STATUS, 32'h0,         30'h0,        32'h0,         1);
        tbl[14] = mk("push_c",     OP_PUSH,   32'hFFFF_FFFF, 30'h0,        32'h0,         3);
        tbl[15] = mk("clr2",       OP_CLEAR,  32'h0,         30'h2AAA_AAAA, 32'h0,        1);
        tbl[16] = mk("stat_clr",   OP_STATUS, 32'h0,         30'h0,        32'h0,         1);
        tbl[17] = mk("read_clr",   OP_READ,   32'h0,         30'h0,        32'h0,         1);

        resetn = 1'b0;
        start  = 1'b0;
        iseId  = 8'h0;
        valueA = 32'h0;
        valueB = 32'h0;
        #1;
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_cmd(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].hi, tbl[i].want, tbl[i].lat);
        end

        // Random pixels against the reference model
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) p[j] = 16'($urandom);
            want = pack_ref(gray_ref(p[0]), gray_ref(p[1]), gray_ref(p[2]), gray_ref(p[3]));
            run_cmd("rnd_clr",  OP_CLEAR, 32'h0,        30'h0, 32'h0, 1);
            run_cmd("rnd_push0", OP_PUSH, {p[1], p[0]}, 30'h0, 32'h0, 3);
            run_cmd("rnd_push1", OP_PUSH, {p[3], p[2]}, 30'h0, 32'h0, 3);
            run_cmd("rnd_read",  OP_READ, 32'h0,        30'h0, want,  1);
        end

        // Start during CONV0 is ignored; exactly one done at +3
        run_cmd("busy_clr", OP_CLEAR, 32'h0, 30'h0, 32'h0, 1);
        @(negedge clock);
        start  = 1'b1;
        iseId  = ID;
        valueA = 32'h0000_FFFF;
        valueB = {30'h0, OP_PUSH};
        @(negedge clock);
        nd = 0;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clock);
            if (done === 1'b1) begin
                nd++;
                if (first == 0) first = k;
                check("busy result", result, 32'h0);
            end
            start  = (k == 1);
            valueB = {30'h0, OP_READ};
        end
        check("busy done count", 32'(nd), 32'd1);
        check("busy done cycle", 32'(first), 32'd3);
        run_cmd("busy_stat", OP_STATUS, 32'h0, 30'h0, 32'h2, 1);

        // ID mismatch: a clear for another ID must leave the count alone
        @(negedge clock);
        start  = 1'b1;
        iseId  = ID ^ 8'h01;
        valueB = {30'h0, OP_CLEAR};
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("id_miss done", {31'd0, done}, 32'd0);
            check("id_miss result", result, 32'd0);
            @(negedge clock);
        end
        run_cmd("id_miss_stat", OP_STATUS, 32'h0, 30'h0, 32'h2, 1);
        run_cmd("id_miss_read", OP_READ, 32'h0, 30'h0, EXP_PART, 1);

        // Asynchronous reset while done is high
        run_cmd("rst_d_push", OP_PUSH, 32'h0000_FFFF, 30'h0, 32'h0, 3);
        @(negedge clock);
        start  = 1'b1;
        iseId  = ID;
        valueB = {30'h0, OP_READ};
        @(negedge clock);
        start = 1'b0;
        check("rst_d pre done", {31'd0, done}, 32'd1);
        check("rst_d pre result", result, EXP_PART);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_d done", {31'd0, done}, 32'd0);
        check("rst_d result", result, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Asynchronous reset in CONV1 discards the push and clears the count
        run_cmd("rst_pre_push", OP_PUSH, 32'hF800_FFFF, 30'h0, 32'h0, 3);
        @(negedge clock);
        start  = 1'b1;
        iseId  = ID;
        valueA = 32'h001F_07E0;
        valueB = {30'h0, OP_PUSH};
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_c1 done", {31'd0, done}, 32'd0);
        check("rst_c1 result", result, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (done === 1'b1) nd++;
        end
        check("rst_c1 no done", 32'(nd), 32'd0);
        run_cmd("rst_c1_stat", OP_STATUS, 32'h0, 30'h0, 32'h0, 1);
        run_cmd("rst_c1_read", OP_READ, 32'h0, 30'h0, 32'h0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
